// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: detects MEM-stage exceptions, flushes and
// redirects the pipeline, then serialises the EPC/Cause/Status updates.
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic        exc_syscall_i,
   input  logic        exc_ri_i,
   input  logic        exc_trap_i,
   input  logic        exc_ov_i,
   input  logic        exc_eret_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_waddr_i,
   input  logic [31:0] wb_wdata_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_wdata_o,
   output logic        cp0_exc_wr_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        stallreq_o,
   output logic [31:0] excepttype_o
);

   typedef enum logic [1:0] {
      IDLE,
      W_EPC,
      W_CAUSE,
      W_STATUS
   } state_t;

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   state_t      state;
   logic [31:0] epc_val;
   logic [31:0] status_snap;
   logic [31:0] cause_snap;
   logic [4:0]  exccode;
   logic        bd;
   logic        is_eret;

   logic        int_pend;
   logic        exc_any;
   logic        exc_eret;
   logic [31:0] exc_type;
   logic [4:0]  exc_code;

   // Priority encoder; an interrupt masks a concurrent eret so the eret is
   // re-executed after the handler returns.
   always_comb begin
      int_pend = mem_valid_i && (|(cause_i[15:8] & status_i[15:8]))
                 && status_i[0] && !status_i[1];
      exc_any  = 1'b0;
      exc_eret = 1'b0;
      exc_type = '0;
      exc_code = '0;
      if (mem_valid_i) begin
         if (int_pend) begin
            exc_any  = 1'b1;
            exc_type = 32'h0000_0001;
            exc_code = 5'd0;
         end else if (exc_syscall_i) begin
            exc_any  = 1'b1;
            exc_type = 32'h0000_0008;
            exc_code = 5'd8;
         end else if (exc_ri_i) begin
            exc_any  = 1'b1;
            exc_type = 32'h0000_000A;
            exc_code = 5'd10;
         end else if (exc_trap_i) begin
            exc_any  = 1'b1;
            exc_type = 32'h0000_000D;
            exc_code = 5'd13;
         end else if (exc_ov_i) begin
            exc_any  = 1'b1;
            exc_type = 32'h0000_000C;
            exc_code = 5'd12;
         end else if (exc_eret_i) begin
            exc_any  = 1'b1;
            exc_eret = 1'b1;
            exc_type = 32'h0000_000E;
            exc_code = 5'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         epc_val     <= '0;
         status_snap <= '0;
         cause_snap  <= '0;
         exccode     <= '0;
         bd          <= 1'b0;
         is_eret     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (exc_any) begin
                  epc_val     <= mem_in_delayslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
                  bd          <= mem_in_delayslot_i;
                  exccode     <= exc_code;
                  status_snap <= status_i;
                  cause_snap  <= cause_i;
                  is_eret     <= exc_eret;
                  // Nested exception (EXL already set) keeps the original EPC/BD.
                  state       <= (exc_eret || status_i[1]) ? W_STATUS : W_EPC;
               end
            end
            W_EPC:    state <= W_CAUSE;
            W_CAUSE:  state <= W_STATUS;
            W_STATUS: state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   always_comb begin
      cp0_we_o     = 1'b0;
      cp0_waddr_o  = '0;
      cp0_wdata_o  = '0;
      cp0_exc_wr_o = 1'b0;
      flush_o      = 1'b0;
      new_pc_o     = '0;
      stallreq_o   = 1'b0;
      excepttype_o = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               cp0_we_o    = wb_we_i;
               cp0_waddr_o = wb_waddr_i;
               cp0_wdata_o = wb_wdata_i;
               if (exc_any) begin
                  flush_o      = 1'b1;
                  new_pc_o     = exc_eret ? epc_i : EXC_VECTOR;
                  excepttype_o = exc_type;
               end
            end
            W_EPC: begin
               cp0_we_o     = 1'b1;
               cp0_exc_wr_o = 1'b1;
               stallreq_o   = 1'b1;
               cp0_waddr_o  = REG_EPC;
               cp0_wdata_o  = epc_val;
            end
            W_CAUSE: begin
               cp0_we_o     = 1'b1;
               cp0_exc_wr_o = 1'b1;
               stallreq_o   = 1'b1;
               cp0_waddr_o  = REG_CAUSE;
               cp0_wdata_o  = {bd, cause_snap[30:7], exccode, cause_snap[1:0]};
            end
            W_STATUS: begin
               cp0_we_o     = 1'b1;
               cp0_exc_wr_o = 1'b1;
               stallreq_o   = 1'b1;
               cp0_waddr_o  = REG_STATUS;
               cp0_wdata_o  = {status_snap[31:2], !is_eret, status_snap[0]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i;
   logic        mem_in_delayslot_i;
   logic        exc_syscall_i, exc_ri_i, exc_trap_i, exc_ov_i, exc_eret_i;
   logic [31:0] status_i, cause_i, epc_i;
   logic        wb_we_i;
   logic [4:0]  wb_waddr_i;
   logic [31:0] wb_wdata_i;
   logic        cp0_we_o;
   logic [4:0]  cp0_waddr_o;
   logic [31:0] cp0_wdata_o;
   logic        cp0_exc_wr_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        stallreq_o;
   logic [31:0] excepttype_o;

   always #5 clk = ~clk;

   cp0_exc_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
      .clk(clk), .rst(rst),
      .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
      .mem_in_delayslot_i(mem_in_delayslot_i),
      .exc_syscall_i(exc_syscall_i), .exc_ri_i(exc_ri_i), .exc_trap_i(exc_trap_i),
      .exc_ov_i(exc_ov_i), .exc_eret_i(exc_eret_i),
      .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
      .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
      .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
      .cp0_exc_wr_o(cp0_exc_wr_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
      .stallreq_o(stallreq_o), .excepttype_o(excepttype_o)
   );

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t pend[$];   // CP0 writes the sequencer still owes, in order

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_exc(output bit taken, output logic [31:0] code);
      bit          f [6];
      logic [31:0] codes [6];
      bit          ip;
      ip = mem_valid_i && ((cause_i[15:8] & status_i[15:8]) != 8'h00)
           && status_i[0] && !status_i[1];
      f = '{ip, exc_syscall_i, exc_ri_i, exc_trap_i, exc_ov_i, exc_eret_i};
      codes = '{32'h1, 32'h8, 32'hA, 32'hD, 32'hC, 32'hE};
      taken = 1'b0;
      code  = '0;
      if (mem_valid_i)
         for (int i = 0; i < 6; i++)
            if (f[i] && !taken) begin
               taken = 1'b1;
               code  = codes[i];
            end
   endtask

   // Settle, compare against the model, then advance the model past the next edge.
   task automatic eval();
      bit          taken;
      logic [31:0] code, c, s, epc;
      logic        e_we, e_exc, e_flush, e_stall;
      logic [4:0]  e_a;
      logic [31:0] e_d, e_pc, e_type;
      #4;
      model_exc(taken, code);
      e_we = 0; e_exc = 0; e_flush = 0; e_stall = 0; e_a = '0; e_d = '0; e_pc = '0; e_type = '0;
      if (rst) begin
      end else if (pend.size() > 0) begin
         e_we = 1; e_exc = 1; e_stall = 1; e_a = pend[0].a; e_d = pend[0].d;
      end else begin
         e_we = wb_we_i; e_a = wb_waddr_i; e_d = wb_wdata_i;
         if (taken) begin
            e_flush = 1; e_type = code;
            e_pc = (code == 32'hE) ? epc_i : 32'h20;
         end
      end
      chk("we", {31'b0, cp0_we_o}, {31'b0, e_we});
      chk("exc_wr", {31'b0, cp0_exc_wr_o}, {31'b0, e_exc});
      chk("flush", {31'b0, flush_o}, {31'b0, e_flush});
      chk("stall", {31'b0, stallreq_o}, {31'b0, e_stall});
      if (e_we || rst) begin
         chk("waddr", {27'b0, cp0_waddr_o}, {27'b0, e_a});
         chk("wdata", cp0_wdata_o, e_d);
      end
      if (e_flush || rst) begin
         chk("new_pc", new_pc_o, e_pc);
         chk("excepttype", excepttype_o, e_type);
      end
      if (rst) pend.delete();
      else if (pend.size() > 0) pend.delete(0);
      else if (taken) begin
         s = status_i;
         if (code == 32'hE) begin
            s[1] = 1'b0;
            pend.push_back('{5'd12, s});
         end else begin
            s[1] = 1'b1;
            if (!status_i[1]) begin
               epc = mem_in_delayslot_i ? mem_pc_i - 32'd4 : mem_pc_i;
               c = cause_i;
               c[31] = mem_in_delayslot_i;
               c[6:2] = (code == 32'h1) ? 5'd0 : code[4:0];
               pend.push_back('{5'd14, epc});
               pend.push_back('{5'd13, c});
            end
            pend.push_back('{5'd12, s});
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      rst = 0; mem_valid_i = 0; mem_pc_i = '0; mem_in_delayslot_i = 0;
      exc_syscall_i = 0; exc_ri_i = 0; exc_trap_i = 0; exc_ov_i = 0; exc_eret_i = 0;
      status_i = '0; cause_i = '0; epc_i = '0;
      wb_we_i = 0; wb_waddr_i = '0; wb_wdata_i = '0;
   endtask

   task automatic exp_wr(input string name, input logic [4:0] a, input logic [31:0] d);
      chk({name, "_we"}, {31'b0, cp0_we_o}, 32'd1);
      chk({name, "_addr"}, {27'b0, cp0_waddr_o}, {27'b0, a});
      chk({name, "_data"}, cp0_wdata_o, d);
      chk({name, "_stall"}, {31'b0, stallreq_o}, 32'd1);
   endtask

   initial begin
      idle_in();
      rst = 1;
      adv();
      eval();
      chk("rst_we", {31'b0, cp0_we_o}, 32'd0);
      chk("rst_flush", {31'b0, flush_o}, 32'd0);
      adv(); eval(); adv();
      rst = 0;

      // Syscall with a concurrent WB mtc0 to Compare
      mem_valid_i = 1; mem_pc_i = 32'h100; exc_syscall_i = 1; status_i = 32'h1000_0001;
      wb_we_i = 1; wb_waddr_i = 5'd11; wb_wdata_i = 32'h55;
      eval();
      chk("sys_flush", {31'b0, flush_o}, 32'd1);
      chk("sys_newpc", new_pc_o, 32'h20);
      chk("sys_type", excepttype_o, 32'h8);
      chk("sys_wb_addr", {27'b0, cp0_waddr_o}, 32'd11);
      chk("sys_wb_data", cp0_wdata_o, 32'h55);
      chk("sys_wb_excwr", {31'b0, cp0_exc_wr_o}, 32'd0);
      adv(); idle_in(); eval(); exp_wr("sys_epc", 5'd14, 32'h100);
      adv(); eval(); exp_wr("sys_cause", 5'd13, 32'h20);
      adv(); eval(); exp_wr("sys_status", 5'd12, 32'h1000_0003);
      adv(); eval(); chk("sys_done_stall", {31'b0, stallreq_o}, 32'd0);
      adv();

      // Overflow in a delay slot
      mem_valid_i = 1; mem_pc_i = 32'h204; mem_in_delayslot_i = 1; exc_ov_i = 1;
      status_i = 32'h1000_0001;
      eval(); chk("ov_type", excepttype_o, 32'hC);
      adv(); idle_in(); eval(); exp_wr("ov_epc", 5'd14, 32'h200);
      adv(); eval(); exp_wr("ov_cause", 5'd13, 32'h8000_0030);
      adv(); eval(); adv(); eval(); adv();

      // Interrupt beats a concurrent overflow
      mem_valid_i = 1; mem_pc_i = 32'h300; exc_ov_i = 1;
      cause_i = 32'h400; status_i = 32'h1000_0401;
      eval(); chk("int_type", excepttype_o, 32'h1);
      adv(); idle_in(); eval(); exp_wr("int_epc", 5'd14, 32'h300);
      adv(); eval(); exp_wr("int_cause", 5'd13, 32'h400);
      adv(); eval(); exp_wr("int_status", 5'd12, 32'h1000_0403);
      adv(); eval(); adv();
      mem_valid_i = 1; cause_i = 32'h400; status_i = 32'h1000_0403;
      eval(); chk("int_exl_noflush", {31'b0, flush_o}, 32'd0);
      adv(); idle_in();

      // eret
      mem_valid_i = 1; exc_eret_i = 1; epc_i = 32'h1234; status_i = 32'h1000_0003;
      eval();
      chk("eret_newpc", new_pc_o, 32'h1234);
      chk("eret_type", excepttype_o, 32'hE);
      adv(); idle_in(); eval(); exp_wr("eret_status", 5'd12, 32'h1000_0001);
      adv(); eval(); chk("eret_stall_end", {31'b0, stallreq_o}, 32'd0);
      adv();

      // Reset while the Cause write is being driven
      mem_valid_i = 1; mem_pc_i = 32'h380; exc_syscall_i = 1; status_i = 32'h1000_0001;
      eval();
      adv(); idle_in(); eval();
      adv(); rst = 1; eval();
      chk("rstw_we", {31'b0, cp0_we_o}, 32'd0);
      chk("rstw_stall", {31'b0, stallreq_o}, 32'd0);
      adv(); rst = 0; eval();
      chk("rstw_after_we", {31'b0, cp0_we_o}, 32'd0);
      adv();
      mem_valid_i = 1; mem_pc_i = 32'h400; exc_syscall_i = 1; status_i = 32'h1000_0001;
      eval(); chk("post_rst_flush", {31'b0, flush_o}, 32'd1);
      adv(); idle_in(); eval(); exp_wr("post_epc", 5'd14, 32'h400);
      adv(); eval(); exp_wr("post_cause", 5'd13, 32'h20);
      adv(); eval(); exp_wr("post_status", 5'd12, 32'h1000_0003);
      adv();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst                = ($urandom_range(99) == 0);
         mem_valid_i        = ($urandom_range(9) != 0);
         mem_pc_i           = $urandom & 32'hFFFF_FFFC;
         mem_in_delayslot_i = $urandom_range(1);
         exc_syscall_i      = ($urandom_range(11) == 0);
         exc_ri_i           = ($urandom_range(11) == 0);
         exc_trap_i         = ($urandom_range(11) == 0);
         exc_ov_i           = ($urandom_range(11) == 0);
         exc_eret_i         = ($urandom_range(11) == 0);
         status_i           = $urandom;
         cause_i            = $urandom;
         if ($urandom_range(1) == 0) cause_i[15:8] = 8'h00;
         epc_i              = $urandom;
         wb_we_i            = (pend.size() == 0) ? 1'($urandom_range(1)) : 1'b0;
         wb_waddr_i         = 5'($urandom);
         wb_wdata_i         = $urandom;
         eval();
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
